// File: rtl/alu_issue_if.sv
// Issue-side bus of the ALU issue unit: request, ALU drive/return and response channels.
interface alu_issue_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_rs1;
    logic [31:0]      in_rs2;
    logic [31:0]      alu_inp1;
    logic [31:0]      alu_inp2;
    logic [3:0]       alu_control;
    logic [31:0]      alu_result;
    logic             zero_flag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_zero;
    logic [4:0]       out_rd;
    logic             out_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport slave (
        input  in_valid, in_instr, in_rs1, in_rs2, alu_result, zero_flag, out_ready,
        output in_ready, alu_inp1, alu_inp2, alu_control,
        output out_valid, out_result, out_zero, out_rd, out_illegal, illegal_cnt
    );

    modport master (
        output in_valid, in_instr, in_rs1, in_rs2, alu_result, zero_flag, out_ready,
        input  in_ready, alu_inp1, alu_inp2, alu_control,
        input  out_valid, out_result, out_zero, out_rd, out_illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_issue_unit.sv
// Two-stage RV32 ALU issue unit: decode into S1 (drives the external ALU), capture
// the ALU result into the response stage, count retired illegal instructions.
module alu_issue_unit #(
    parameter int CNT_W = 8
) (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        d_ill;
    logic [3:0]  d_ctrl;
    logic [31:0] d_b;

    logic             s1_valid;
    logic [3:0]       s1_ctrl;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [4:0]       s1_rd;
    logic             s1_ill;
    logic             s1_adv;
    logic             accept;
    logic             retire;
    logic             out_valid_q;
    logic [31:0]      out_result_q;
    logic             out_zero_q;
    logic [4:0]       out_rd_q;
    logic             out_ill_q;
    logic [CNT_W-1:0] ill_cnt;

    assign opcode = bus.in_instr[6:0];
    assign funct3 = bus.in_instr[14:12];
    assign funct7 = bus.in_instr[31:25];

    always_comb begin
        d_ill  = 1'b0;
        d_ctrl = 4'b0010;
        d_b    = bus.in_rs2;
        case (opcode)
            7'b0110011: begin
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  d_ctrl = 4'b0010;
                            3'b111:  d_ctrl = 4'b0000;
                            3'b110:  d_ctrl = 4'b0001;
                            3'b100:  d_ctrl = 4'b0111;
                            3'b001:  d_ctrl = 4'b0011;
                            3'b101:  d_ctrl = 4'b0101;
                            3'b011:  d_ctrl = 4'b1000;
                            default: d_ill  = 1'b1;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) d_ctrl = 4'b0100;
                        else                  d_ill  = 1'b1;
                    end
                    7'b0000001: begin
                        if (funct3 == 3'b000) d_ctrl = 4'b0110;
                        else                  d_ill  = 1'b1;
                    end
                    default: d_ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                d_b = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
                case (funct3)
                    3'b000: d_ctrl = 4'b0010;
                    3'b111: d_ctrl = 4'b0000;
                    3'b110: d_ctrl = 4'b0001;
                    3'b100: d_ctrl = 4'b0111;
                    3'b011: d_ctrl = 4'b1000;
                    3'b001: begin
                        d_ctrl = 4'b0011;
                        d_b    = {27'd0, bus.in_instr[24:20]};
                        d_ill  = (funct7 != 7'b0000000);
                    end
                    3'b101: begin
                        // SRAI lands here with funct7 0100000 and is rejected
                        d_ctrl = 4'b0101;
                        d_b    = {27'd0, bus.in_instr[24:20]};
                        d_ill  = (funct7 != 7'b0000000);
                    end
                    default: d_ill = 1'b1;
                endcase
            end
            default: d_ill = 1'b1;
        endcase
    end

    assign s1_adv = s1_valid && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = !s1_valid || s1_adv;
    assign accept = bus.in_valid && bus.in_ready;
    assign retire = out_valid_q && bus.out_ready;

    // Illegal entries are sanitised on capture so the ALU drive is the S1 registers verbatim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_ctrl  <= 4'd0;
            s1_a     <= 32'd0;
            s1_b     <= 32'd0;
            s1_rd    <= 5'd0;
            s1_ill   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_ctrl  <= d_ill ? 4'b0010 : d_ctrl;
            s1_a     <= d_ill ? 32'd0 : bus.in_rs1;
            s1_b     <= d_ill ? 32'd0 : d_b;
            s1_rd    <= bus.in_instr[11:7];
            s1_ill   <= d_ill;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_result_q <= 32'd0;
            out_zero_q   <= 1'b0;
            out_rd_q     <= 5'd0;
            out_ill_q    <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q  <= 1'b1;
            out_result_q <= s1_ill ? 32'd0 : bus.alu_result;
            out_zero_q   <= s1_ill ? 1'b0 : bus.zero_flag;
            out_rd_q     <= s1_rd;
            out_ill_q    <= s1_ill;
        end else if (retire) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt <= '0;
        end else if (retire && out_ill_q && !(&ill_cnt)) begin
            ill_cnt <= ill_cnt + CNT_W'(1);
        end
    end

    assign bus.alu_control = s1_ctrl;
    assign bus.alu_inp1    = s1_a;
    assign bus.alu_inp2    = s1_b;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_zero    = out_zero_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_illegal = out_ill_q;
    assign bus.illegal_cnt = ill_cnt;
endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: vector table through the pipeline, backpressure and reset sequences.
module tb_alu_issue_unit;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    alu_issue_if #(.CNT_W(CNT_W)) bus ();

    alu_issue_unit #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference combinational ALU sitting outside the DUT
    always_comb begin
        bus.alu_result = 32'd0;
        case (bus.alu_control)
            4'b0010: bus.alu_result = bus.alu_inp1 + bus.alu_inp2;
            4'b0100: bus.alu_result = bus.alu_inp1 - bus.alu_inp2;
            4'b0000: bus.alu_result = bus.alu_inp1 & bus.alu_inp2;
            4'b0001: bus.alu_result = bus.alu_inp1 | bus.alu_inp2;
            4'b0111: bus.alu_result = bus.alu_inp1 ^ bus.alu_inp2;
            4'b0011: bus.alu_result = bus.alu_inp1 << bus.alu_inp2[4:0];
            4'b0101: bus.alu_result = bus.alu_inp1 >> bus.alu_inp2[4:0];
            4'b1000: bus.alu_result = {31'd0, bus.alu_inp1 < bus.alu_inp2};
            4'b0110: bus.alu_result = bus.alu_inp1 * bus.alu_inp2;
            default: bus.alu_result = 32'd0;
        endcase
        bus.zero_flag = (bus.alu_result == 32'd0);
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] result;
        logic        zero;
        logic        ill;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_cnt;

    initial begin
        vecs[0]  = '{r_ins(7'h00, 3'b000, 5'd3),  32'd5,      32'd7,      4'b0010, 32'd5,      32'd7,          32'd12,     1'b0, 1'b0, 5'd3};
        vecs[1]  = '{r_ins(7'h20, 3'b000, 5'd4),  32'd9,      32'd9,      4'b0100, 32'd9,      32'd9,          32'd0,      1'b1, 1'b0, 5'd4};
        vecs[2]  = '{i_ins(12'hFFF, 3'b000, 5'd5), 32'd1,     32'd99,     4'b0010, 32'd1,      32'hFFFF_FFFF,  32'd0,      1'b1, 1'b0, 5'd5};
        vecs[3]  = '{r_ins(7'h00, 3'b111, 5'd6),  32'hF0F0,   32'hFF00,   4'b0000, 32'hF0F0,   32'hFF00,       32'hF000,   1'b0, 1'b0, 5'd6};
        vecs[4]  = '{i_ins(12'h00F, 3'b110, 5'd7), 32'hF0,    32'd0,      4'b0001, 32'hF0,     32'h0F,         32'hFF,     1'b0, 1'b0, 5'd7};
        vecs[5]  = '{r_ins(7'h00, 3'b100, 5'd8),  32'hAA,     32'h0F,     4'b0111, 32'hAA,     32'h0F,         32'hA5,     1'b0, 1'b0, 5'd8};
        vecs[6]  = '{i_ins(12'h004, 3'b001, 5'd9), 32'd3,     32'd0,      4'b0011, 32'd3,      32'd4,          32'h30,     1'b0, 1'b0, 5'd9};
        vecs[7]  = '{r_ins(7'h00, 3'b101, 5'd10), 32'h80,     32'd3,      4'b0101, 32'h80,     32'd3,          32'h10,     1'b0, 1'b0, 5'd10};
        vecs[8]  = '{i_ins(12'hFFF, 3'b011, 5'd11), 32'd5,    32'd0,      4'b1000, 32'd5,      32'hFFFF_FFFF,  32'd1,      1'b0, 1'b0, 5'd11};
        vecs[9]  = '{r_ins(7'h01, 3'b000, 5'd12), 32'd6,      32'd7,      4'b0110, 32'd6,      32'd7,          32'd42,     1'b0, 1'b0, 5'd12};
        vecs[10] = '{i_ins(12'h01F, 3'b101, 5'd13), 32'h8000_0000, 32'd0, 4'b0101, 32'h8000_0000, 32'h1F,      32'd1,      1'b0, 1'b0, 5'd13};
        vecs[11] = '{i_ins(12'h401, 3'b101, 5'd14), 32'd8,    32'd0,      4'b0010, 32'd0,      32'd0,          32'd0,      1'b0, 1'b1, 5'd14};
        vecs[12] = '{{12'h000, 5'd1, 3'b010, 5'd15, 7'b0000011}, 32'd4, 32'd4, 4'b0010, 32'd0, 32'd0,          32'd0,      1'b0, 1'b1, 5'd15};
        vecs[13] = '{r_ins(7'h00, 3'b010, 5'd16), 32'd1,      32'd2,      4'b0010, 32'd0,      32'd0,          32'd0,      1'b0, 1'b1, 5'd16};
        vecs[14] = '{r_ins(7'h01, 3'b001, 5'd17), 32'd3,      32'd3,      4'b0010, 32'd0,      32'd0,          32'd0,      1'b0, 1'b1, 5'd17};
        vecs[15] = '{i_ins(12'h020, 3'b001, 5'd18), 32'd3,    32'd0,      4'b0010, 32'd0,      32'd0,          32'd0,      1'b0, 1'b1, 5'd18};

        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_rs1    = 32'd0;
        bus.in_rs2    = 32'd0;
        bus.out_ready = 1'b1;
        exp_cnt       = 2'd0;

        repeat (2) tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_cnt", {30'd0, bus.illegal_cnt}, 32'd0);
        chk("rst_alu_ctrl", {28'd0, bus.alu_control}, 32'd0);
        chk("rst_alu_inp1", bus.alu_inp1, 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            bus.in_instr = vecs[i].instr;
            bus.in_rs1   = vecs[i].rs1;
            bus.in_rs2   = vecs[i].rs2;
            bus.in_valid = 1'b1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
            tick();
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d_alu_ctrl", i), {28'd0, bus.alu_control}, {28'd0, vecs[i].ctrl});
            chk($sformatf("v%0d_alu_inp1", i), bus.alu_inp1, vecs[i].a);
            chk($sformatf("v%0d_alu_inp2", i), bus.alu_inp2, vecs[i].b);
            chk($sformatf("v%0d_out_valid_early", i), {31'd0, bus.out_valid}, 32'd0);
            tick();
            chk($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("v%0d_out_result", i), bus.out_result, vecs[i].result);
            chk($sformatf("v%0d_out_zero", i), {31'd0, bus.out_zero}, {31'd0, vecs[i].zero});
            chk($sformatf("v%0d_out_rd", i), {27'd0, bus.out_rd}, {27'd0, vecs[i].rd});
            chk($sformatf("v%0d_out_illegal", i), {31'd0, bus.out_illegal}, {31'd0, vecs[i].ill});
            tick();
            if (vecs[i].ill && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            chk($sformatf("v%0d_illegal_cnt", i), {30'd0, bus.illegal_cnt}, {30'd0, exp_cnt});
            chk($sformatf("v%0d_drained", i), {31'd0, bus.out_valid}, 32'd0);
        end

        // Backpressure: three back-to-back requests while the consumer stalls
        bus.out_ready = 1'b0;
        bus.in_instr = r_ins(7'h00, 3'b000, 5'd1); bus.in_rs1 = 32'd1;  bus.in_rs2 = 32'd2;  bus.in_valid = 1'b1;
        tick();
        bus.in_instr = r_ins(7'h00, 3'b000, 5'd2); bus.in_rs1 = 32'd10; bus.in_rs2 = 32'd20;
        tick();
        bus.in_instr = r_ins(7'h20, 3'b000, 5'd3); bus.in_rs1 = 32'd5;  bus.in_rs2 = 32'd3;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp%0d_in_ready", k), {31'd0, bus.in_ready}, 32'd0);
            chk($sformatf("bp%0d_out_valid", k), {31'd0, bus.out_valid}, 32'd1);
            chk($sformatf("bp%0d_out_result", k), bus.out_result, 32'd3);
            chk($sformatf("bp%0d_out_rd", k), {27'd0, bus.out_rd}, 32'd1);
            chk($sformatf("bp%0d_alu_inp1", k), bus.alu_inp1, 32'd10);
            chk($sformatf("bp%0d_alu_inp2", k), bus.alu_inp2, 32'd20);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("bp_second_result", bus.out_result, 32'd30);
        chk("bp_second_rd", {27'd0, bus.out_rd}, 32'd2);
        chk("bp_third_alu_ctrl", {28'd0, bus.alu_control}, 32'd4);
        tick();
        chk("bp_third_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_third_result", bus.out_result, 32'd2);
        chk("bp_third_rd", {27'd0, bus.out_rd}, 32'd3);
        tick();
        chk("bp_empty", {31'd0, bus.out_valid}, 32'd0);

        // Reset with both stages occupied
        bus.out_ready = 1'b0;
        bus.in_instr = {12'h000, 5'd1, 3'b010, 5'd7, 7'b0000011}; bus.in_valid = 1'b1;
        tick();
        bus.in_instr = r_ins(7'h00, 3'b000, 5'd8); bus.in_rs1 = 32'd4; bus.in_rs2 = 32'd4;
        tick();
        bus.in_valid = 1'b0;
        chk("pre_rst_full", {31'd0, bus.in_ready}, 32'd0);
        chk("pre_rst_cnt", {30'd0, bus.illegal_cnt}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_rst_cnt", {30'd0, bus.illegal_cnt}, 32'd0);
        chk("mid_rst_alu_ctrl", {28'd0, bus.alu_control}, 32'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("post_rst%0d_out_valid", k), {31'd0, bus.out_valid}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-002 SHALL use one clock and an asynchronous, active-low reset:
  clk          in   1   rising-edge clock
  rst_n        in   1   asynchronous reset, active low
REQ-003 SHALL provide these ports:
  in_valid     in   1   request valid
  in_ready     out  1   request accepted when in_valid&&in_ready
  in_instr     in   32  RV32 instruction word
  in_rs1       in   32  rs1 operand value
  in_rs2       in   32  rs2 operand value
  alu_inp1     out  32  ALU operand A
  alu_inp2     out  32  ALU operand B
  alu_control  out  4   ALU op code
  alu_result   in   32  combinational ALU result
  zero_flag    in   1   ALU zero flag
  out_valid    out  1   response valid
  out_ready    in   1   response consumed when out_valid&&out_ready
  out_result   out  32  captured result
  out_zero     out  1   captured zero flag
  out_rd       out  5   destination register, in_instr[11:7]
  out_illegal  out  1   instruction not supported
  illegal_cnt  out  CNT_W  retired illegal instructions, saturating

Function
REQ-004 SHALL decode opcode 0110011 (R) and 0010011 (I); all other opcodes SHALL be illegal.
REQ-005 SHALL map ops to alu_control: ADD/ADDI 0010, SUB 0100, AND/ANDI 0000, OR/ORI 0001, XOR/XORI 0111, SLL/SLLI 0011, SRL/SRLI 0101, SLTU/SLTIU 1000, MUL (funct7 0000001, funct3 000) 0110.
REQ-006 SHALL treat SLT, SLTI, SRA, SRAI, other M-extension ops, R-type funct7 not in {0000000, 0100000 for SUB only, 0000001 for MUL}, and SLLI/SRLI with imm[11:5]!=0 as illegal.
REQ-007 SHALL set alu_inp2 for I-type to sign-extended in_instr[31:20]; for SLLI/SRLI to zero-extended in_instr[24:20].
REQ-008 SHALL be a two-stage pipeline: stage 1 (S1) registers alu_control, alu_inp1, alu_inp2, rd, illegal; stage 2 registers alu_result, zero_flag into out_* .
REQ-009 SHALL drive alu_* from S1 registers only; an illegal S1 entry SHALL drive alu_control 0010, alu_inp1 0, alu_inp2 0.
REQ-010 SHALL deassert in_ready only when S1 is full and S1 cannot advance.
REQ-011 SHALL advance S1 to stage 2 when S1 is full and (!out_valid || out_ready); S1 SHALL accept a new request in the same cycle (full throughput).
REQ-012 SHALL give latency 2: accepted at edge N -> alu_* valid after N -> out_valid after edge N+1 when out_ready was held high.
REQ-013 SHALL hold out_* and alu_* stable while out_valid && !out_ready.
REQ-014 SHALL for illegal entries output out_result 0, out_zero 0, out_illegal 1, ignoring the ALU.
REQ-015 SHALL increment illegal_cnt on each illegal response consumed, saturating at 2^CNT_W-1.
REQ-016 SHALL, on simultaneous accept and retire, process both in one cycle with no lost or duplicated entry.

Reset
REQ-017 SHALL, while rst_n low, clear S1 valid, out_valid, out_result, out_zero, out_rd, out_illegal, illegal_cnt, alu_control, alu_inp1, alu_inp2 to 0, and in_ready SHALL read 1 after reset.
REQ-018 SHALL discard in-flight entries on reset assertion mid-operation; nothing is emitted after release until a new accept.

Verification
REQ-019 ADD x3 (rs1=5, rs2=7), out_ready=1 -> alu_control 0010 cycle+1, out_valid cycle+2, out_result 12, out_zero 0, out_rd 3.
REQ-020 SUB rs1=rs2=9 -> alu_control 0100, out_result 0, out_zero 1.
REQ-021 ADDI imm=0xFFF, rs1=1 -> alu_inp2 0xFFFFFFFF, out_result 0.
REQ-022 out_ready=0 with 3 back-to-back requests -> two held (stage 2, S1), in_ready 0, outputs stable; release -> three results in order, one per cycle.
REQ-023 opcode 0000011 and SRAI, CNT_W=2, 5 illegal retired -> out_illegal 1, out_result 0, illegal_cnt saturates at 3.
REQ-024 rst_n pulsed low with both stages full -> out_valid 0, in_ready 1, illegal_cnt 0, no response after release.
